// File: rtl/regbank_pkg.sv
// Shared definitions for the register bank and its writeback arbiter.
package regbank_pkg;

  localparam int unsigned NREGS = 32;
  localparam int unsigned RAW   = 5;
  localparam int unsigned DW    = 32;

  typedef struct packed {
    logic           valid;
    logic [RAW-1:0] addr;
    logic [DW-1:0]  data;
  } wb_req_t;

  // One-hot write enable for registers 1..31. Address 0 (hardwired zero)
  // decodes to an all-zero vector because bit 0 is dropped.
  function automatic logic [NREGS-1:1] onehot_dec(input logic [RAW-1:0] addr);
    logic [NREGS-1:0] v_full;
    v_full       = '0;
    v_full[addr] = 1'b1;
    return v_full[NREGS-1:1];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating-priority grant plus the pointer register.
// Grant is combinational and same-cycle; the pointer moves past the winner.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_stall,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_gnt_idx,
  output logic          o_accept
);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;

  // Search from r_ptr upward with wrap; first valid requester wins.
  always_comb begin : grant_search
    int unsigned   v_idx;
    logic [PW-1:0] v_sel;
    v_idx     = 0;
    v_sel     = '0;
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_accept  = 1'b0;
    if (i_rst_n && !i_stall) begin
      for (int unsigned i = 0; i < N; i++) begin
        v_idx = (32'(r_ptr) + i) % N;
        v_sel = PW'(v_idx);
        if (!o_accept && i_req[v_sel]) begin
          o_accept     = 1'b1;
          o_gnt[v_sel] = 1'b1;
          o_gnt_idx    = v_sel;
        end
      end
    end
  end

  // Next pointer: one past the winner, modulo N; hold when nothing accepted.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (o_accept) begin
      w_ptr_nxt = (o_gnt_idx == PW'(N - 1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // At most one grant per cycle.
  a_gnt_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(o_gnt));

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Writeback arbiter for the 31-entry register bank: picks one writeback
// source per cycle, registers it, and drives the bank write port plus a
// forwarding tap carrying the same registered write.
module regbank_wb_arbiter
  import regbank_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_stall,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0][RAW-1:0]  req_addr,
  input  logic [NREQ-1:0][DW-1:0]   req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic [31:1]               addrw,
  output logic [DW-1:0]             wdata,
  output logic                      fwd_valid,
  output logic [RAW-1:0]            fwd_addr,
  output logic [DW-1:0]             fwd_data
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_gnt_idx;
  logic            w_accept;
  logic [RAW-1:0]  w_sel_addr;
  logic [DW-1:0]   w_sel_data;
  logic            w_nonzero;

  logic [31:1]     r_addrw;
  logic [DW-1:0]   r_wdata;
  logic            r_fwd_valid;
  logic [RAW-1:0]  r_fwd_addr;

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_stall   (wb_stall),
    .i_req     (req_valid),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_accept  (w_accept)
  );

  // Select the winning request's address and data.
  always_comb begin
    w_sel_addr = req_addr[w_gnt_idx];
    w_sel_data = req_data[w_gnt_idx];
    w_nonzero  = (w_sel_addr != '0);
  end

  // Writeback stage. A write to x0 is consumed but never enables the bank;
  // data and address still load so the tap reflects the last accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addrw     <= '0;
      r_wdata     <= '0;
      r_fwd_valid <= 1'b0;
      r_fwd_addr  <= '0;
    end else if (w_accept) begin
      r_addrw     <= w_nonzero ? onehot_dec(w_sel_addr) : '0;
      r_wdata     <= w_sel_data;
      r_fwd_valid <= w_nonzero;
      r_fwd_addr  <= w_sel_addr;
    end else begin
      r_addrw     <= '0;
      r_fwd_valid <= 1'b0;
    end
  end

  assign req_ready = w_gnt;
  assign addrw     = r_addrw;
  assign wdata     = r_wdata;
  assign fwd_valid = r_fwd_valid;
  assign fwd_addr  = r_fwd_addr;
  assign fwd_data  = r_wdata;

  // Bank write enable is never more than one-hot.
  a_addrw_onehot0: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(r_addrw));

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter with a small register-bank model
// that captures addrw/wdata on each rising edge.
module tb_regbank_wb_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned DW   = 32;

  logic                   clk;
  logic                   reset;
  logic                   wb_stall;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0][4:0]   req_addr;
  logic [NREQ-1:0][DW-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic [31:1]            addrw;
  logic [DW-1:0]          wdata;
  logic                   fwd_valid;
  logic [4:0]             fwd_addr;
  logic [DW-1:0]          fwd_data;

  logic [31:0] bank [1:31];

  int n_checks;
  int n_fail;

  regbank_wb_arbiter #(
    .NREQ (NREQ),
    .DW   (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_stall  (wb_stall),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .addrw     (addrw),
    .wdata     (wdata),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank model.
  always @(posedge clk) begin
    for (int i = 1; i < 32; i++) begin
      if (addrw[i]) bank[i] <= wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fairness table: granted vector and resulting addrw / wdata.
  logic [2:0]  fair_gnt   [6];
  logic [30:0] fair_addrw [6];
  logic [31:0] fair_data  [6];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 1; i < 32; i++) bank[i] = '0;

    fair_gnt   = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    fair_addrw = '{31'h0000_0200, 31'h0008_0000, 31'h4000_0000,
                   31'h0000_0200, 31'h0008_0000, 31'h4000_0000};
    fair_data  = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222,
                   32'hA000_0000, 32'hA111_1111, 32'hA222_2222};

    // Reset held with every requester valid.
    reset     = 1'b0;
    wb_stall  = 1'b0;
    req_valid = 3'b111;
    req_addr  = '{5'd9, 5'd7, 5'd5};
    req_data  = '{32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    tick();
    tick();
    check("rst_ready",  64'(req_ready), 64'h0);
    check("rst_addrw",  64'(addrw),     64'h0);
    check("rst_fwdv",   64'(fwd_valid), 64'h0);
    check("rst_wdata",  64'(wdata),     64'h0);
    check("rst_fwda",   64'(fwd_addr),  64'h0);
    check("rst_fwdd",   64'(fwd_data),  64'h0);

    // Single write from req0 to r5; first grant after reset is requester 0.
    reset     = 1'b1;
    req_valid = 3'b001;
    #1;
    check("w1_ready", 64'(req_ready), 64'h1);
    tick();
    check("w1_addrw", 64'(addrw),     64'h10);
    check("w1_wdata", 64'(wdata),     64'hDEAD_BEEF);
    check("w1_fwdv",  64'(fwd_valid), 64'h1);
    check("w1_fwda",  64'(fwd_addr),  64'd5);
    check("w1_fwdd",  64'(fwd_data),  64'hDEAD_BEEF);
    req_valid = 3'b000;
    #1;
    check("idle_ready", 64'(req_ready), 64'h0);
    tick();
    check("idle_addrw", 64'(addrw),     64'h0);
    check("idle_fwdv",  64'(fwd_valid), 64'h0);
    check("idle_wdata", 64'(wdata),     64'hDEAD_BEEF);
    check("bank_r5",    64'(bank[5]),   64'hDEAD_BEEF);

    // Write to x0 from req1 (ptr=1): consumed, no bank enable.
    req_valid   = 3'b010;
    req_addr[1] = 5'd0;
    req_data[1] = 32'h0000_1234;
    #1;
    check("x0_ready", 64'(req_ready), 64'h2);
    tick();
    check("x0_addrw", 64'(addrw),     64'h0);
    check("x0_fwdv",  64'(fwd_valid), 64'h0);
    check("x0_wdata", 64'(wdata),     64'h1234);
    check("x0_fwda",  64'(fwd_addr),  64'h0);

    // Pointer now at 2: with all valid, requester 2 wins.
    req_valid   = 3'b111;
    req_addr[2] = 5'd3;
    req_data[2] = 32'h3333_3333;
    #1;
    check("ptr2_ready", 64'(req_ready), 64'h4);
    tick();
    check("ptr2_addrw", 64'(addrw), 64'h4);

    // Fairness: all valid for 6 cycles starting with ptr=0.
    req_addr = '{5'd31, 5'd20, 5'd10};
    req_data = '{32'hA222_2222, 32'hA111_1111, 32'hA000_0000};
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("fair_ready%0d", k), 64'(req_ready), 64'(fair_gnt[k]));
      tick();
      check($sformatf("fair_addrw%0d", k), 64'(addrw), 64'(fair_addrw[k]));
      check($sformatf("fair_wdata%0d", k), 64'(wdata), 64'(fair_data[k]));
    end
    check("bank_r31", 64'(bank[31]), 64'hA222_2222);

    // One more grant to move ptr to 1 before stalling.
    #1;
    check("pre_stall_ready", 64'(req_ready), 64'h1);
    tick();

    // Stall for 3 cycles; the write registered before the stall still shows.
    wb_stall = 1'b1;
    check("stall_inflight", 64'(addrw), 64'h200);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall_ready%0d", k), 64'(req_ready), 64'h0);
      tick();
      check($sformatf("stall_addrw%0d", k), 64'(addrw), 64'h0);
    end
    wb_stall = 1'b0;
    #1;
    check("resume_ready", 64'(req_ready), 64'h2);
    tick();
    check("resume_addrw", 64'(addrw),     64'h0008_0000);
    check("resume_fwdv",  64'(fwd_valid), 64'h1);

    // Reset mid-write: req2 to r31 accepted, then reset during the write cycle.
    req_data[2] = 32'hCAFE_F00D;
    #1;
    check("rmw_ready", 64'(req_ready), 64'h4);
    tick();
    check("rmw_addrw", 64'(addrw), 64'h4000_0000);
    check("rmw_wdata", 64'(wdata), 64'hCAFE_F00D);
    reset = 1'b0;
    #1;
    check("rmw_addrw_clr", 64'(addrw),     64'h0);
    check("rmw_fwdv_clr",  64'(fwd_valid), 64'h0);
    check("rmw_wdata_clr", 64'(wdata),     64'h0);
    check("rmw_ready_clr", 64'(req_ready), 64'h0);
    tick();
    check("rmw_bank_r31", 64'(bank[31]), 64'hA222_2222);

    // Release reset: arbitration restarts at requester 0.
    reset = 1'b1;
    #1;
    check("rel_ready", 64'(req_ready), 64'h1);
    tick();
    check("rel_addrw", 64'(addrw), 64'h200);
    req_valid = 3'b000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
